dpramsampleunpacker: RTL and testbench
======================================

// Module: dpramSampleUnpacker
// PURPOSE
//  Read-side companion to genericDPRAM waveform capture. Fetches wide words
//  (SAMPLES_PER_WORD packed samples) from the DPRAM read port and emits them
//  as a narrow valid/ready sample stream, lane 0 first.
//  Feeds readout/streaming logic that consumes one sample per clock.
// PARAMETERS
//  READ_ADDRESS_WIDTH  10   DPRAM read address width (words)
//  READ_DATA_WIDTH     256  DPRAM read data width
//  SAMPLE_WIDTH        16   output sample width
//  (local) SAMPLES_PER_WORD = READ_DATA_WIDTH/SAMPLE_WIDTH, power of 2, >= 4
// PORTS
//  clk          in   1                     system clock, DPRAM rClk
//  reset        in   1                     sync, active-high
//  start        in   1                     begin transfer (sampled in S_IDLE only)
//  startAddr    in   READ_ADDRESS_WIDTH    first word address
//  wordCount    in   READ_ADDRESS_WIDTH+1  words to read; 0 = empty transfer
//  busy         out  1                     transfer in progress
//  done         out  1                     1-cycle pulse at transfer end
//  rAddr        out  READ_ADDRESS_WIDTH    DPRAM read address (registered)
//  rData        in   READ_DATA_WIDTH       DPRAM read data, 1-cycle latency
//  sampleValid  out  1                     sampleData valid
//  sampleReady  in   1                     consumer accepts
//  sampleData   out  SAMPLE_WIDTH          current sample
//  sampleLast   out  1                     final sample of transfer
// BEHAVIOUR
//  Reset: busy=0, done=0, rAddr=0, sampleValid=0, sampleData=0,
//    sampleLast=0, state S_IDLE, both word buffers empty.
//  States: S_IDLE -> S_RUN on start (wordCount!=0); S_IDLE -> S_DONE on
//    start with wordCount==0; S_RUN -> S_DONE when last sample accepted;
//    S_DONE -> S_IDLE after one cycle (done=1 in S_DONE).
//  busy=1 in S_RUN and S_DONE. start ignored outside S_IDLE.
//  Sample i of word w = rData[i*SAMPLE_WIDTH +: SAMPLE_WIDTH], i=0 first.
//  Transfer = beat on sampleValid&&sampleReady. While sampleValid=1 and
//    sampleReady=0, sampleData/sampleLast held stable.
//  Two word buffers: active (being shifted out) + prefetch. Issue next
//    rAddr whenever prefetch slot free, no fetch in flight, words remain.
//    Capture rData one cycle after rAddr issued.
//  Latency: start in cycle 0 -> rAddr=startAddr cycle 1 -> sampleValid cycle 3.
//  Throughput: with sampleReady held 1, no bubbles after first sample,
//    including across word boundaries.
//  rAddr increments modulo 2^READ_ADDRESS_WIDTH (wraps to 0).
//  Words remaining counter width READ_ADDRESS_WIDTH+1; full-depth transfer
//    (wordCount=2^READ_ADDRESS_WIDTH) legal.
//  sampleLast=1 only on lane SAMPLES_PER_WORD-1 of final word.
//  done pulses the cycle after the last beat; busy drops with done.
//  Reset mid-transfer: abandon transfer, all outputs to reset values next
//    cycle, no done pulse; in-flight read data discarded.
// TESTING
//  (RAM model: word w lane i = {w[7:0], i[7:0]}; SAMPLES_PER_WORD=16.)
//  1 startAddr=0, wordCount=8, ready=1 -> 128 samples {w,i} in order,
//    contiguous valid, last on sample 127, done next cycle.
//  2 same, sampleReady 50% random -> identical sequence; data stable
//    while stalled; no samples lost or duplicated.
//  3 wordCount=0 -> done pulse cycle 1, busy high only that cycle, no sampleValid.
//  4 startAddr=1022, wordCount=4 -> rAddr sequence 1022,1023,0,1; 64 samples.
//  5 start in cycle 0 -> sampleValid first in cycle 3; wordCount=1 ->
//    sampleLast on 16th sample; start pulses while busy ignored.
//  6 reset after 20 samples -> next cycle all outputs at reset values,
//    no done; new start afterwards completes correctly.

Source files
------------

// File: rtl/dpramsampleunpacker.sv
// -----------------------------------------------------------------------------
// dpramsampleunpacker
//
// Read-side companion to the waveform-capture DPRAM. Fetches wide words
// (SAMPLES_PER_WORD packed samples) from the DPRAM read port and emits them
// lane 0 first as a narrow valid/ready sample stream, one sample per clock.
//
// Ports
//   i_clk           system clock, also the DPRAM read clock
//   i_reset         synchronous, active-high reset
//   i_start         begin a transfer (only honoured while idle)
//   i_start_addr    first word address
//   i_word_count    number of words to read; 0 gives an empty transfer
//   o_busy          transfer in progress (run and done phases)
//   o_done          one-cycle pulse the cycle after the final beat
//   o_r_addr        DPRAM read address (registered)
//   i_r_data        DPRAM read data, one cycle after o_r_addr
//   o_sample_valid  o_sample_data holds a sample
//   i_sample_ready  consumer accepts the current sample
//   o_sample_data   current sample
//   o_sample_last   final sample of the transfer
// -----------------------------------------------------------------------------
module dpramsampleunpacker #(
  parameter int READ_ADDRESS_WIDTH = 10,
  parameter int READ_DATA_WIDTH    = 256,
  parameter int SAMPLE_WIDTH       = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [READ_ADDRESS_WIDTH-1:0] i_start_addr,
  input  logic [READ_ADDRESS_WIDTH:0]   i_word_count,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [READ_ADDRESS_WIDTH-1:0] o_r_addr,
  input  logic [READ_DATA_WIDTH-1:0]    i_r_data,
  output logic                          o_sample_valid,
  input  logic                          i_sample_ready,
  output logic [SAMPLE_WIDTH-1:0]       o_sample_data,
  output logic                          o_sample_last
);

  localparam int SAMPLES_PER_WORD = READ_DATA_WIDTH / SAMPLE_WIDTH;
  localparam int LANE_W           = $clog2(SAMPLES_PER_WORD);

  localparam logic [LANE_W-1:0]           LANE_ZERO = {LANE_W{1'b0}};
  localparam logic [LANE_W-1:0]           LANE_ONE  = {{(LANE_W-1){1'b0}}, 1'b1};
  localparam logic [LANE_W-1:0]           LANE_MAX  = {LANE_W{1'b1}};
  localparam logic [READ_ADDRESS_WIDTH:0] CNT_ZERO  = {(READ_ADDRESS_WIDTH+1){1'b0}};
  localparam logic [READ_ADDRESS_WIDTH:0] CNT_ONE   = {{READ_ADDRESS_WIDTH{1'b0}}, 1'b1};
  localparam logic [READ_ADDRESS_WIDTH-1:0] ADDR_ONE = {{(READ_ADDRESS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [READ_DATA_WIDTH-1:0]  WORD_ZERO = {READ_DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Registered state
  state_t                         r_state;
  logic [READ_ADDRESS_WIDTH-1:0]  r_r_addr;
  logic [READ_ADDRESS_WIDTH:0]    r_words_left;  // words not yet issued
  logic                           r_issue;       // address on o_r_addr this cycle
  logic                           r_issue_last;
  logic                           r_capture;     // i_r_data valid this cycle
  logic                           r_capture_last;
  logic [READ_DATA_WIDTH-1:0]     r_act_word;    // shifts right, lane 0 at bottom
  logic                           r_act_valid;
  logic                           r_act_last;
  logic [LANE_W-1:0]              r_lane;
  logic [READ_DATA_WIDTH-1:0]     r_pf_word;
  logic                           r_pf_valid;
  logic                           r_pf_last;
  logic                           r_sample_last;
  logic                           r_busy;
  logic                           r_done;

  // Next-state values
  state_t                         w_state_nxt;
  logic [READ_ADDRESS_WIDTH-1:0]  w_r_addr_nxt;
  logic [READ_ADDRESS_WIDTH:0]    w_words_left_nxt;
  logic                           w_issue_nxt;
  logic                           w_issue_last_nxt;
  logic                           w_capture_nxt;
  logic                           w_capture_last_nxt;
  logic [READ_DATA_WIDTH-1:0]     w_act_word_nxt;
  logic                           w_act_valid_nxt;
  logic                           w_act_last_nxt;
  logic [LANE_W-1:0]              w_lane_nxt;
  logic [READ_DATA_WIDTH-1:0]     w_pf_word_nxt;
  logic                           w_pf_valid_nxt;
  logic                           w_pf_last_nxt;

  logic w_beat;
  logic w_lane_end;
  logic w_final_beat;
  logic w_act_free;
  logic w_issue_ok;

  assign w_beat       = r_act_valid & i_sample_ready;
  assign w_lane_end   = (r_lane == LANE_MAX);
  assign w_final_beat = w_beat & w_lane_end & r_act_last;
  // Active buffer can take a new word this cycle (empty, or its last lane leaves now).
  assign w_act_free   = ~r_act_valid | (w_beat & w_lane_end);
  // Only one read in flight at a time, and only when its landing slot is free.
  assign w_issue_ok   = ~r_pf_valid & ~r_issue & ~r_capture & (r_words_left != CNT_ZERO);

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_r_addr       = r_r_addr;
  assign o_sample_valid = r_act_valid;
  assign o_sample_data  = r_act_word[SAMPLE_WIDTH-1:0];
  assign o_sample_last  = r_sample_last;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, fetch scheduling and buffer management
  always_comb begin
    w_state_nxt        = r_state;
    w_r_addr_nxt       = r_r_addr;
    w_words_left_nxt   = r_words_left;
    w_issue_nxt        = r_issue;
    w_issue_last_nxt   = r_issue_last;
    w_capture_nxt      = r_capture;
    w_capture_last_nxt = r_capture_last;
    w_act_word_nxt     = r_act_word;
    w_act_valid_nxt    = r_act_valid;
    w_act_last_nxt     = r_act_last;
    w_lane_nxt         = r_lane;
    w_pf_word_nxt      = r_pf_word;
    w_pf_valid_nxt     = r_pf_valid;
    w_pf_last_nxt      = r_pf_last;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_word_count == CNT_ZERO) begin
            w_state_nxt = S_DONE;
          end else begin
            // First fetch goes out immediately: address visible next cycle.
            w_state_nxt      = S_RUN;
            w_r_addr_nxt     = i_start_addr;
            w_words_left_nxt = i_word_count - CNT_ONE;
            w_issue_nxt      = 1'b1;
            w_issue_last_nxt = (i_word_count == CNT_ONE);
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_RUN: begin
        w_capture_nxt      = r_issue;
        w_capture_last_nxt = r_issue_last;
        w_issue_nxt        = 1'b0;

        if (w_final_beat) begin
          w_state_nxt     = S_DONE;
          w_act_word_nxt  = WORD_ZERO;
          w_act_valid_nxt = 1'b0;
          w_act_last_nxt  = 1'b0;
          w_lane_nxt      = LANE_ZERO;
          w_pf_valid_nxt  = 1'b0;
          w_pf_last_nxt   = 1'b0;
          w_capture_nxt   = 1'b0;
        end else begin
          if (w_act_free) begin
            if (r_pf_valid) begin
              // Promote prefetch; a read landing now refills the prefetch slot.
              w_act_word_nxt  = r_pf_word;
              w_act_last_nxt  = r_pf_last;
              w_act_valid_nxt = 1'b1;
              w_lane_nxt      = LANE_ZERO;
              w_pf_valid_nxt  = r_capture;
              w_pf_word_nxt   = r_capture ? i_r_data : r_pf_word;
              w_pf_last_nxt   = r_capture_last;
            end else if (r_capture) begin
              w_act_word_nxt  = i_r_data;
              w_act_last_nxt  = r_capture_last;
              w_act_valid_nxt = 1'b1;
              w_lane_nxt      = LANE_ZERO;
            end else begin
              w_act_valid_nxt = 1'b0;
              w_lane_nxt      = LANE_ZERO;
            end
          end else begin
            if (w_beat) begin
              w_act_word_nxt = r_act_word >> SAMPLE_WIDTH;
              w_lane_nxt     = r_lane + LANE_ONE;
            end else begin
              w_act_word_nxt = r_act_word;
            end
            if (r_capture) begin
              w_pf_word_nxt  = i_r_data;
              w_pf_valid_nxt = 1'b1;
              w_pf_last_nxt  = r_capture_last;
            end else begin
              w_pf_valid_nxt = r_pf_valid;
            end
          end

          if (w_issue_ok) begin
            w_issue_nxt      = 1'b1;
            w_issue_last_nxt = (r_words_left == CNT_ONE);
            w_words_left_nxt = r_words_left - CNT_ONE;
            w_r_addr_nxt     = r_r_addr + ADDR_ONE;  // wraps modulo 2^READ_ADDRESS_WIDTH
          end else begin
            w_issue_nxt = 1'b0;
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_r_addr       <= {READ_ADDRESS_WIDTH{1'b0}};
      r_words_left   <= CNT_ZERO;
      r_issue        <= 1'b0;
      r_issue_last   <= 1'b0;
      r_capture      <= 1'b0;
      r_capture_last <= 1'b0;
      r_act_word     <= WORD_ZERO;
      r_act_valid    <= 1'b0;
      r_act_last     <= 1'b0;
      r_lane         <= LANE_ZERO;
      r_pf_word      <= WORD_ZERO;
      r_pf_valid     <= 1'b0;
      r_pf_last      <= 1'b0;
      r_sample_last  <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_r_addr       <= w_r_addr_nxt;
      r_words_left   <= w_words_left_nxt;
      r_issue        <= w_issue_nxt;
      r_issue_last   <= w_issue_last_nxt;
      r_capture      <= w_capture_nxt;
      r_capture_last <= w_capture_last_nxt;
      r_act_word     <= w_act_word_nxt;
      r_act_valid    <= w_act_valid_nxt;
      r_act_last     <= w_act_last_nxt;
      r_lane         <= w_lane_nxt;
      r_pf_word      <= w_pf_word_nxt;
      r_pf_valid     <= w_pf_valid_nxt;
      r_pf_last      <= w_pf_last_nxt;
      r_sample_last  <= w_act_valid_nxt & w_act_last_nxt & (w_lane_nxt == LANE_MAX);
      r_busy         <= (w_state_nxt != S_IDLE);
      r_done         <= (w_state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_dpramsampleunpacker.sv
// -----------------------------------------------------------------------------
// tb_dpramsampleunpacker
//
// Directed and randomized transfers against dpramsampleunpacker. The RAM model
// holds {addr[7:0], lane[7:0]} in each lane; expected samples are computed
// arithmetically from the start address and word count.
// -----------------------------------------------------------------------------
module tb_dpramsampleunpacker;

  localparam int AW  = 10;
  localparam int DW  = 256;
  localparam int SW  = 16;
  localparam int SPW = DW / SW;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [AW-1:0] i_start_addr;
  logic [AW:0]   i_word_count;
  logic          o_busy;
  logic          o_done;
  logic [AW-1:0] o_r_addr;
  logic [DW-1:0] i_r_data;
  logic          o_sample_valid;
  logic          i_sample_ready;
  logic [SW-1:0] o_sample_data;
  logic          o_sample_last;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dpramsampleunpacker #(
    .READ_ADDRESS_WIDTH(AW),
    .READ_DATA_WIDTH   (DW),
    .SAMPLE_WIDTH      (SW)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_start_addr  (i_start_addr),
    .i_word_count  (i_word_count),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_r_addr      (o_r_addr),
    .i_r_data      (i_r_data),
    .o_sample_valid(o_sample_valid),
    .i_sample_ready(i_sample_ready),
    .o_sample_data (o_sample_data),
    .o_sample_last (o_sample_last)
  );

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    logic [7:0]    ib;
    w = '0;
    for (int i = 0; i < SPW; i++) begin
      ib = 8'(i);
      w[i*SW +: SW] = {a[7:0], ib};
    end
    return w;
  endfunction

  // DPRAM read port: one cycle of latency
  always @(posedge clk) i_r_data <= ram_word(o_r_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  64'(o_busy), 64'd0);
    chk({tag, "_done"},  64'(o_done), 64'd0);
    chk({tag, "_raddr"}, 64'(o_r_addr), 64'd0);
    chk({tag, "_valid"}, 64'(o_sample_valid), 64'd0);
    chk({tag, "_data"},  64'(o_sample_data), 64'd0);
    chk({tag, "_last"},  64'(o_sample_last), 64'd0);
  endtask

  // One transfer: start at cycle 0, observe each cycle at the falling edge.
  task automatic run_xfer(input int sa, input int wc, input bit rnd, input int abort_at, input bit poke);
    int exp_q[$];
    int addr_seen[$];
    int cyc, first_valid, last_beat, busy_cycles, beats, total, budget, e, n;
    bit ready, prev_stall, prev_last, finished;
    logic [SW-1:0] prev_data;

    total = wc * SPW;
    for (int w = 0; w < wc; w++)
      for (int i = 0; i < SPW; i++)
        exp_q.push_back((((sa + w) % 1024) % 256) * 256 + i);
    budget      = 60 + total * 8;
    first_valid = -1;
    last_beat   = -1;
    busy_cycles = 0;
    beats       = 0;
    prev_stall  = 1'b0;
    prev_last   = 1'b0;
    prev_data   = '0;
    finished    = 1'b0;

    @(negedge clk);
    i_start_addr   = AW'(sa);
    i_word_count   = (AW+1)'(wc);
    i_start        = 1'b1;
    i_sample_ready = 1'b1;
    cyc = 0;

    while (!finished && cyc < budget) begin
      @(negedge clk);
      cyc++;
      i_start      = 1'b0;
      i_start_addr = AW'(sa);
      i_word_count = (AW+1)'(wc);
      if (poke && (cyc == 2 || cyc == 9)) begin
        i_start      = 1'b1;
        i_start_addr = AW'(500);
        i_word_count = (AW+1)'(3);
      end
      if (o_busy) busy_cycles++;
      if (cyc == 1 || int'(o_r_addr) != addr_seen[$]) addr_seen.push_back(int'(o_r_addr));

      if (prev_stall) begin
        chk("stall_valid", 64'(o_sample_valid), 64'd1);
        chk("stall_data",  64'(o_sample_data), 64'(prev_data));
        chk("stall_last",  64'(o_sample_last), 64'(prev_last));
      end

      if (o_done) begin
        chk("done_cycle", 64'(cyc), 64'((wc == 0) ? 1 : last_beat + 1));
        chk("done_no_valid", 64'(o_sample_valid), 64'd0);
        chk("busy_span", 64'(busy_cycles), 64'(cyc));
        @(negedge clk);
        chk("busy_drop", 64'(o_busy), 64'd0);
        chk("done_pulse", 64'(o_done), 64'd0);
        finished = 1'b1;
      end else begin
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        i_sample_ready = ready;
        if (o_sample_valid && first_valid < 0) begin
          first_valid = cyc;
          if (!rnd) chk("first_valid_cycle", 64'(cyc), 64'd3);
        end
        if (o_sample_valid && ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_sample", 64'(o_sample_data), 64'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("sample_data", 64'(o_sample_data), 64'(e));
            chk("sample_last", 64'(o_sample_last), 64'(exp_q.size() == 0));
          end
          beats++;
          if (!rnd) chk("contiguous", 64'(cyc), 64'(first_valid + beats - 1));
          last_beat = cyc;
          if (abort_at > 0 && beats == abort_at) begin
            i_reset = 1'b1;
            @(negedge clk);
            check_reset_outputs("abort");
            i_reset = 1'b0;
            repeat (6) begin
              @(negedge clk);
              chk("abort_no_done", 64'(o_done), 64'd0);
              chk("abort_no_valid", 64'(o_sample_valid), 64'd0);
            end
            finished = 1'b1;
          end
        end
        prev_stall = o_sample_valid && !ready;
        prev_data  = o_sample_data;
        prev_last  = o_sample_last;
      end
    end

    chk("completed", 64'(finished), 64'd1);
    if (abort_at == 0) begin
      chk("beat_count", 64'(beats), 64'(total));
      if (wc > 0) begin
        chk("addr_count", 64'(addr_seen.size()), 64'(wc));
        n = (addr_seen.size() < wc) ? addr_seen.size() : wc;
        for (int k = 0; k < n; k++)
          chk("raddr_seq", 64'(addr_seen[k]), 64'((sa + k) % 1024));
      end
    end
  endtask

  initial begin
    i_reset        = 1'b1;
    i_start        = 1'b0;
    i_start_addr   = '0;
    i_word_count   = '0;
    i_sample_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    i_reset = 1'b0;

    run_xfer(0, 8, 1'b0, 0, 1'b0);     // full rate, 128 samples
    run_xfer(0, 8, 1'b1, 0, 1'b0);     // random backpressure
    run_xfer(0, 0, 1'b0, 0, 1'b0);     // empty transfer
    run_xfer(1022, 4, 1'b0, 0, 1'b0);  // address wrap
    run_xfer(0, 1, 1'b0, 0, 1'b1);     // single word, starts while busy ignored
    run_xfer(3, 8, 1'b0, 20, 1'b0);    // reset after 20 samples
    run_xfer(5, 2, 1'b1, 0, 1'b0);     // clean transfer after abort
    repeat (3) run_xfer(int'($urandom_range(0, 1023)), int'($urandom_range(1, 4)), 1'b1, 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
